store_write_buffer: RTL and testbench

//  Sits between the LSU store path and the data-memory port. Holds translated stores
//  (phy_store_t) in a speculative FIFO until the commit stage retires them. Retired stores

---
 rtl/tortoise_pkg.sv | 24 ++
 rtl/store_write_buffer_if.sv | 29 ++
 rtl/store_write_buffer_fifo.sv | 65 ++++++
 rtl/store_write_buffer.sv | 89 ++++++++
 tb/tb_store_write_buffer.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tortoise_pkg.sv
// Core-wide types shared by the load/store unit and its store write buffer.
// Store data is one doubleword; size encodes the access width within it.
package tortoise_pkg;

  localparam int XLEN              = 64;
  localparam int WB_SPEC_ENTRIES   = 4;
  localparam int WB_COMMIT_ENTRIES = 3;

  typedef logic [XLEN-1:0] addr_t;

  typedef enum logic [1:0] {
    SZ_B  = 2'd0,
    SZ_H  = 2'd1,
    SZ_W  = 2'd2,
    SZ_DW = 2'd3
  } size_t;

  typedef struct packed {
    addr_t            addr;
    size_t            size;
    logic [XLEN-1:0]  data;
  } phy_store_t;

endpackage

// File: rtl/store_write_buffer_if.sv
// LSU/commit/memory-facing signals of the store write buffer, grouped as one bundle.
// The slave modport is the buffer; master is the surrounding pipeline and memory port.
interface store_write_buffer_if;
  import tortoise_pkg::*;

  logic       flush;
  logic       st_valid;
  logic       st_ready;
  phy_store_t st_data;
  logic       commit;
  logic       commit_ready;
  logic       mem_req;
  logic       mem_gnt;
  phy_store_t mem_store;
  addr_t      ld_addr;
  logic       ld_hit;
  logic       empty;

  modport master (
    output flush, st_valid, st_data, commit, mem_gnt, ld_addr,
    input  st_ready, commit_ready, mem_req, mem_store, ld_hit, empty
  );

  modport slave (
    input  flush, st_valid, st_data, commit, mem_gnt, ld_addr,
    output st_ready, commit_ready, mem_req, mem_store, ld_hit, empty
  );

endinterface

// File: rtl/store_write_buffer_fifo.sv
// Circular FIFO of any depth with clear; exposes every slot and its liveness for snooping.
// Head data is read straight from storage; the caller must not push when full or pop when empty.
module wb_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = tortoise_pkg::phy_store_t
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  T                             push_dat,
  input  logic                         pop,
  input  logic                         clear,
  output T                             head_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [DEPTH-1:0]             slot_vld,
  output T                             slots [DEPTH]
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  T              mem [DEPTH];

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] inc(logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= tail;
      count <= '0;
    end else begin
      if (push) tail <= inc(tail);
      if (pop)  head <= inc(head);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[tail] <= push_dat;
  end

  assign head_dat = mem[head];
  assign slots    = mem;

  always_comb begin
    slot_vld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_vld[i] = ((i + DEPTH - int'(head)) % DEPTH) < int'(count);
    end
  end

  no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(push && (count == CW'(DEPTH))));
  no_pop_empty: assert property (@(posedge clk) disable iff (rst)
    !(pop && (count == '0)));

endmodule

// File: rtl/store_write_buffer.sv
// Holds speculative stores until commit, then drains committed stores to memory in order.
// Push-to-mem_req is 2 cycles; st_ready/commit_ready come from registered occupancy only.
module store_write_buffer
  import tortoise_pkg::*;
#(
  parameter int SPEC_ENTRIES   = WB_SPEC_ENTRIES,
  parameter int COMMIT_ENTRIES = WB_COMMIT_ENTRIES
) (
  input logic                 clk,
  input logic                 rst,
  store_write_buffer_if.slave bus
);

  localparam int SCW = $clog2(SPEC_ENTRIES + 1);
  localparam int CCW = $clog2(COMMIT_ENTRIES + 1);

  logic                      st_ready;
  logic                      commit_ready;
  logic                      mem_req;
  logic                      spec_push;
  logic                      commit_fire;
  logic                      mem_pop;
  logic                      hit;
  logic [SCW-1:0]            spec_cnt;
  logic [CCW-1:0]            com_cnt;
  logic [SPEC_ENTRIES-1:0]   spec_vld;
  logic [COMMIT_ENTRIES-1:0] com_vld;
  phy_store_t                spec_head;
  phy_store_t                com_head;
  phy_store_t                spec_slots [SPEC_ENTRIES];
  phy_store_t                com_slots  [COMMIT_ENTRIES];

  assign st_ready     = int'(spec_cnt) < SPEC_ENTRIES;
  assign commit_ready = (spec_cnt != '0) && (int'(com_cnt) < COMMIT_ENTRIES);
  assign mem_req      = (com_cnt != '0);

  // A push racing a flush belongs to the squashed path, so it is dropped.
  assign spec_push   = bus.st_valid && st_ready && !bus.flush;
  assign commit_fire = bus.commit && commit_ready;
  assign mem_pop     = bus.mem_gnt && mem_req;

  wb_fifo #(.DEPTH(SPEC_ENTRIES), .T(phy_store_t)) u_spec (
    .clk      (clk),
    .rst      (rst),
    .push     (spec_push),
    .push_dat (bus.st_data),
    .pop      (commit_fire),
    .clear    (bus.flush),
    .head_dat (spec_head),
    .count    (spec_cnt),
    .slot_vld (spec_vld),
    .slots    (spec_slots)
  );

  wb_fifo #(.DEPTH(COMMIT_ENTRIES), .T(phy_store_t)) u_commit (
    .clk      (clk),
    .rst      (rst),
    .push     (commit_fire),
    .push_dat (spec_head),
    .pop      (mem_pop),
    .clear    (1'b0),
    .head_dat (com_head),
    .count    (com_cnt),
    .slot_vld (com_vld),
    .slots    (com_slots)
  );

  // Doubleword-granule match, ignoring size: conservative by design.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < SPEC_ENTRIES; i++) begin
      if (spec_vld[i] && (spec_slots[i].addr[XLEN-1:3] == bus.ld_addr[XLEN-1:3])) hit = 1'b1;
    end
    for (int i = 0; i < COMMIT_ENTRIES; i++) begin
      if (com_vld[i] && (com_slots[i].addr[XLEN-1:3] == bus.ld_addr[XLEN-1:3])) hit = 1'b1;
    end
  end

  assign bus.st_ready     = st_ready;
  assign bus.commit_ready = commit_ready;
  assign bus.mem_req      = mem_req;
  assign bus.mem_store    = com_head;
  assign bus.ld_hit       = hit;
  assign bus.empty        = (spec_cnt == '0) && (com_cnt == '0);

  commit_only_when_ready: assert property (@(posedge clk) disable iff (rst)
    bus.commit |-> commit_ready);

endmodule

// File: tb/tb_store_write_buffer.sv
// Store write buffer bench: directed scenarios plus random traffic against a queue-based model.
// The model tracks the two FIFOs as queues and derives every output from their sizes and contents.
module tb_store_write_buffer;
  import tortoise_pkg::*;

  localparam int S = WB_SPEC_ENTRIES;
  localparam int C = WB_COMMIT_ENTRIES;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  phy_store_t spec_q[$];
  phy_store_t com_q[$];
  phy_store_t got_q[$];

  store_write_buffer_if bus ();

  store_write_buffer #(.SPEC_ENTRIES(S), .COMMIT_ENTRIES(C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic phy_store_t mk(addr_t a, size_t s, logic [63:0] d);
    phy_store_t p;
    p.addr = a;
    p.size = s;
    p.data = d;
    return p;
  endfunction

  function automatic phy_store_t rnd_store();
    return mk(addr_t'(64'h2000 + 64'($urandom_range(0, 63))),
              size_t'($urandom_range(0, 3)), {$urandom, $urandom});
  endfunction

  function automatic logic m_hit(addr_t a);
    foreach (spec_q[i]) if (spec_q[i].addr[XLEN-1:3] == a[XLEN-1:3]) return 1'b1;
    foreach (com_q[i])  if (com_q[i].addr[XLEN-1:3] == a[XLEN-1:3]) return 1'b1;
    return 1'b0;
  endfunction

  // Model update with the inputs currently driven, then advance one clock.
  task automatic tick();
    logic p, c, g;
    if (rst) begin
      spec_q.delete();
      com_q.delete();
    end else begin
      p = bus.st_valid && (spec_q.size() < S);
      c = bus.commit && (spec_q.size() > 0) && (com_q.size() < C);
      g = bus.mem_gnt && (com_q.size() > 0);
      if (g) void'(com_q.pop_front());
      if (c) com_q.push_back(spec_q.pop_front());
      if (bus.flush) spec_q.delete();
      else if (p) spec_q.push_back(bus.st_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.st_valid = 1'b0;
    bus.st_data  = '0;
    bus.commit   = 1'b0;
    bus.flush    = 1'b0;
    bus.mem_gnt  = 1'b0;
    bus.ld_addr  = '0;
  endtask

  // Commits and drains until the buffer is empty, collecting what memory accepts.
  task automatic drain_all();
    got_q.delete();
    bus.st_valid = 1'b0;
    bus.flush    = 1'b0;
    for (int n = 0; n < 200; n++) begin
      bus.mem_gnt = 1'b1;
      bus.commit  = (spec_q.size() > 0) && (com_q.size() < C);
      #1;
      if (bus.empty && spec_q.size() == 0 && com_q.size() == 0) break;
      if (bus.mem_req) got_q.push_back(bus.mem_store);
      tick();
    end
    bus.commit  = 1'b0;
    bus.mem_gnt = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++; if (bus.st_ready !== 1'b1) begin errors++; $display("FAIL reset_st_ready got %b want 1", bus.st_ready); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", bus.empty); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", bus.mem_req); end
    checks++; if (bus.commit_ready !== 1'b0) begin errors++; $display("FAIL reset_commit_ready got %b want 0", bus.commit_ready); end
    checks++; if (bus.ld_hit !== 1'b0) begin errors++; $display("FAIL reset_ld_hit got %b want 0", bus.ld_hit); end
  endtask

  task automatic test_basic();
    phy_store_t s;
    s = mk(64'h8000_0010, SZ_DW, 64'hAA);
    idle();
    bus.mem_gnt  = 1'b1;
    bus.st_valid = 1'b1;
    bus.st_data  = s;
    tick();
    bus.st_valid = 1'b0;
    checks++; if (bus.commit_ready !== 1'b1) begin errors++; $display("FAIL basic_commit_ready got %b want 1", bus.commit_ready); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL basic_req_early got %b want 0", bus.mem_req); end
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL basic_mem_req got %b want 1", bus.mem_req); end
    checks++; if (bus.mem_store !== s) begin errors++; $display("FAIL basic_mem_store got %h want %h", bus.mem_store, s); end
    tick();
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL basic_empty got %b want 1", bus.empty); end
    bus.mem_gnt = 1'b0;
  endtask

  task automatic test_full();
    phy_store_t exp_q[$];
    idle();
    for (int i = 0; i < S; i++) begin
      bus.st_valid = 1'b1;
      bus.st_data  = rnd_store();
      exp_q.push_back(bus.st_data);
      tick();
    end
    bus.st_valid = 1'b0;
    checks++; if (bus.st_ready !== 1'b0) begin errors++; $display("FAIL full_st_ready got %b want 0", bus.st_ready); end
    bus.st_valid = 1'b1;
    bus.st_data  = rnd_store();
    tick();
    bus.st_valid = 1'b0;
    checks++; if (bus.st_ready !== 1'b0) begin errors++; $display("FAIL full_still_full got %b want 0", bus.st_ready); end
    drain_all();
    checks++; if (got_q.size() != S) begin errors++; $display("FAIL full_drain_count got %0d want %0d", got_q.size(), S); end
    for (int i = 0; i < S && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL full_order[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL full_empty got %b want 1", bus.empty); end
  endtask

  task automatic test_flush_commit();
    phy_store_t a, b;
    a = rnd_store();
    b = rnd_store();
    idle();
    bus.st_valid = 1'b1; bus.st_data = a; tick();
    bus.st_data  = b; tick();
    bus.st_valid = 1'b0;
    bus.commit = 1'b1; bus.flush = 1'b1; tick();
    bus.commit = 1'b0; bus.flush = 1'b0;
    checks++; if (bus.commit_ready !== 1'b0) begin errors++; $display("FAIL flush_commit_ready got %b want 0", bus.commit_ready); end
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL flush_mem_req got %b want 1", bus.mem_req); end
    bus.st_valid = 1'b1; bus.st_data = rnd_store(); bus.flush = 1'b1; tick();
    bus.st_valid = 1'b0; bus.flush = 1'b0;
    checks++; if (bus.commit_ready !== 1'b0) begin errors++; $display("FAIL flush_push_dropped got %b want 0", bus.commit_ready); end
    drain_all();
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL flush_drain_count got %0d want 1", got_q.size()); end
    checks++; if (got_q.size() > 0 && got_q[0] !== a) begin errors++; $display("FAIL flush_survivor got %h want %h", got_q[0], a); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL flush_empty got %b want 1", bus.empty); end
  endtask

  task automatic test_stall();
    phy_store_t a, b;
    a = rnd_store();
    b = rnd_store();
    idle();
    bus.st_valid = 1'b1; bus.st_data = a; tick();
    bus.st_data  = b; bus.commit = 1'b1; tick();
    bus.st_valid = 1'b0; tick();
    bus.commit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL stall_req[%0d] got %b want 1", i, bus.mem_req); end
      checks++; if (bus.mem_store !== a) begin errors++; $display("FAIL stall_data[%0d] got %h want %h", i, bus.mem_store, a); end
      tick();
    end
    bus.mem_gnt = 1'b1; tick(); bus.mem_gnt = 1'b0;
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL stall_next_req got %b want 1", bus.mem_req); end
    checks++; if (bus.mem_store !== b) begin errors++; $display("FAIL stall_next_data got %h want %h", bus.mem_store, b); end
    tick();
    checks++; if (bus.mem_store !== b) begin errors++; $display("FAIL stall_one_pop got %h want %h", bus.mem_store, b); end
    bus.mem_gnt = 1'b1; tick(); bus.mem_gnt = 1'b0;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL stall_empty got %b want 1", bus.empty); end
  endtask

  task automatic test_ld_hit();
    idle();
    bus.st_valid = 1'b1;
    bus.st_data  = mk(64'h1000, SZ_W, 64'h1234_5678);
    tick();
    bus.st_valid = 1'b0;
    bus.ld_addr = 64'h1004; #1;
    checks++; if (bus.ld_hit !== 1'b1) begin errors++; $display("FAIL hit_spec_same got %b want 1", bus.ld_hit); end
    bus.ld_addr = 64'h1008; #1;
    checks++; if (bus.ld_hit !== 1'b0) begin errors++; $display("FAIL hit_spec_next got %b want 0", bus.ld_hit); end
    bus.commit = 1'b1; tick(); bus.commit = 1'b0;
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL hit_moved got %b want 1", bus.mem_req); end
    bus.ld_addr = 64'h1004; #1;
    checks++; if (bus.ld_hit !== 1'b1) begin errors++; $display("FAIL hit_com_same got %b want 1", bus.ld_hit); end
    bus.ld_addr = 64'h1008; #1;
    checks++; if (bus.ld_hit !== 1'b0) begin errors++; $display("FAIL hit_com_next got %b want 0", bus.ld_hit); end
    drain_all();
    bus.ld_addr = 64'h1004; #1;
    checks++; if (bus.ld_hit !== 1'b0) begin errors++; $display("FAIL hit_after_drain got %b want 0", bus.ld_hit); end
  endtask

  task automatic test_reset_midop();
    idle();
    bus.st_valid = 1'b1; bus.st_data = rnd_store(); tick();
    bus.st_data  = rnd_store(); bus.commit = 1'b1; tick();
    bus.st_valid = 1'b0; bus.commit = 1'b0;
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL midrst_req_before got %b want 1", bus.mem_req); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL midrst_req got %b want 0", bus.mem_req); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL midrst_empty got %b want 1", bus.empty); end
  endtask

  task automatic test_random();
    logic e;
    for (int n = 0; n < 800; n++) begin
      rst          = ($urandom_range(0, 149) == 0);
      bus.st_valid = 1'($urandom_range(0, 1));
      bus.st_data  = rnd_store();
      bus.commit   = ($urandom_range(0, 1) == 1) && (spec_q.size() > 0) && (com_q.size() < C);
      bus.flush    = ($urandom_range(0, 9) == 0);
      bus.mem_gnt  = ($urandom_range(0, 2) != 0);
      bus.ld_addr  = addr_t'(64'h2000 + 64'($urandom_range(0, 63)));
      #1;
      e = (spec_q.size() < S);
      checks++; if (bus.st_ready !== e) begin errors++; $display("FAIL rnd_st_ready @%0d got %b want %b", n, bus.st_ready, e); end
      e = (spec_q.size() > 0) && (com_q.size() < C);
      checks++; if (bus.commit_ready !== e) begin errors++; $display("FAIL rnd_commit_ready @%0d got %b want %b", n, bus.commit_ready, e); end
      e = (com_q.size() > 0);
      checks++; if (bus.mem_req !== e) begin errors++; $display("FAIL rnd_mem_req @%0d got %b want %b", n, bus.mem_req, e); end
      e = (spec_q.size() == 0) && (com_q.size() == 0);
      checks++; if (bus.empty !== e) begin errors++; $display("FAIL rnd_empty @%0d got %b want %b", n, bus.empty, e); end
      e = m_hit(bus.ld_addr);
      checks++; if (bus.ld_hit !== e) begin errors++; $display("FAIL rnd_ld_hit @%0d got %b want %b", n, bus.ld_hit, e); end
      if (com_q.size() > 0) begin
        checks++; if (bus.mem_store !== com_q[0]) begin errors++; $display("FAIL rnd_mem_store @%0d got %h want %h", n, bus.mem_store, com_q[0]); end
      end
      tick();
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_basic();
    test_full();
    test_flush_commit();
    test_stall();
    test_ld_hit();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
